// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter between the
// inertial and A2D sensor interfaces.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic OWN_INERT = 1'b0;
    localparam logic OWN_A2D   = 1'b1;

    localparam logic [15:0] RSP_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/spi_arb.sv
// Shares one SPI master between the inertial and A2D interfaces: arbitrates,
// routes SS_n, returns responses, enforces bus gaps and a hung-transfer watchdog.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int MAX_INERT_CONSEC = 4,
    parameter int GAP_CYC          = 8,
    parameter int TIMEOUT          = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inert_req,
    input  logic [15:0] inert_cmd,
    output logic        inert_done,
    output logic [15:0] inert_rsp,
    input  logic        a2d_req,
    input  logic [15:0] a2d_cmd,
    output logic        a2d_done,
    output logic [15:0] a2d_rsp,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rsp,
    input  logic        spi_SS_n,
    output logic        INERT_SS_n,
    output logic        A2D_SS_n,
    output logic        owner,
    output logic        timeout_err,
    input  logic        err_clr
);

    // One counter serves both the gap hold and the BUSY watchdog.
    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CON_W   = $clog2(MAX_INERT_CONSEC + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CON_W-1:0] CON_MAX  = CON_W'(MAX_INERT_CONSEC);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CON_W-1:0]  r_consec;
    logic              r_owner;
    logic [15:0]       r_spi_cmd;
    logic              r_spi_wrt;
    logic [15:0]       r_inert_rsp;
    logic [15:0]       r_a2d_rsp;
    logic              r_timeout_err;

    logic              w_any_req;
    logic              w_pick_a2d;
    logic              w_timeout;
    logic              w_capture;
    logic              w_active;
    logic [15:0]       w_rsp_val;

    always_comb begin
        w_any_req  = inert_req | a2d_req;
        w_pick_a2d = a2d_req & (~inert_req | (r_consec == CON_MAX));
        w_timeout  = (r_state == BUSY) && !spi_done && (r_cnt == TO_LAST);
        w_capture  = (r_state == BUSY) && (spi_done || w_timeout);
        w_rsp_val  = spi_done ? spi_rsp : RSP_TIMEOUT;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        inert_done  = 1'b0;
        a2d_done    = 1'b0;
        INERT_SS_n  = 1'b1;
        A2D_SS_n    = 1'b1;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = BUSY;
            BUSY:    if (spi_done || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = GAP;
            GAP:     if (r_cnt == GAP_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_active = (r_state == ISSUE) || (r_state == BUSY) || (r_state == RESP);
        if (w_active && (r_owner == OWN_INERT)) INERT_SS_n = spi_SS_n;
        if (w_active && (r_owner == OWN_A2D))   A2D_SS_n   = spi_SS_n;
        if (r_state == RESP) begin
            inert_done = (r_owner == OWN_INERT);
            a2d_done   = (r_owner == OWN_A2D);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == BUSY) || (r_state == GAP)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_consec      <= '0;
            r_owner       <= OWN_INERT;
            r_spi_cmd     <= '0;
            r_spi_wrt     <= 1'b0;
            r_inert_rsp   <= '0;
            r_a2d_rsp     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_wrt <= (r_state == ISSUE);
            if ((r_state == IDLE) && w_any_req) begin
                r_owner   <= w_pick_a2d ? OWN_A2D : OWN_INERT;
                r_spi_cmd <= w_pick_a2d ? a2d_cmd : inert_cmd;
                // Only inertial grants made while A2D waits count toward forcing A2D.
                if (w_pick_a2d || !a2d_req)  r_consec <= '0;
                else if (r_consec != CON_MAX) r_consec <= r_consec + CON_W'(1);
            end
            if (w_capture) begin
                if (r_owner == OWN_A2D) r_a2d_rsp   <= w_rsp_val;
                else                    r_inert_rsp <= w_rsp_val;
            end
            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (err_clr) r_timeout_err <= 1'b0;
        end
    end

    assign spi_wrt     = r_spi_wrt;
    assign spi_cmd     = r_spi_cmd;
    assign owner       = r_owner;
    assign inert_rsp   = r_inert_rsp;
    assign a2d_rsp     = r_a2d_rsp;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: stimulus queues expected SPI writes and done
// responses, a monitor pops and compares them as the DUT presents them.
module tb_spi_arb;

    localparam int GAP_CYC = 8;
    localparam int TIMEOUT = 4096;
    localparam int MAXC    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inert_req, a2d_req, err_clr;
    logic [15:0] inert_cmd, a2d_cmd;
    logic        inert_done, a2d_done;
    logic [15:0] inert_rsp, a2d_rsp;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rsp;
    logic        spi_SS_n;
    logic        INERT_SS_n, A2D_SS_n;
    logic        owner, timeout_err;

    always #5 clk = ~clk;

    spi_arb #(
        .MAX_INERT_CONSEC(MAXC),
        .GAP_CYC(GAP_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inert_req(inert_req), .inert_cmd(inert_cmd),
        .inert_done(inert_done), .inert_rsp(inert_rsp),
        .a2d_req(a2d_req), .a2d_cmd(a2d_cmd),
        .a2d_done(a2d_done), .a2d_rsp(a2d_rsp),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_rsp(spi_rsp), .spi_SS_n(spi_SS_n),
        .INERT_SS_n(INERT_SS_n), .A2D_SS_n(A2D_SS_n),
        .owner(owner), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    typedef struct {
        logic        own;
        logic [15:0] val;
        int          lat;
    } exp_t;

    exp_t q_wrt[$];
    exp_t q_done[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name, string msg);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, msg);
    endfunction

    function automatic void push_w(logic own, logic [15:0] cmd);
        exp_t e;
        e.own = own; e.val = cmd; e.lat = 0;
        q_wrt.push_back(e);
    endfunction

    function automatic void push_d(logic own, logic [15:0] rsp, int lat);
        exp_t e;
        e.own = own; e.val = rsp; e.lat = lat;
        q_done.push_back(e);
    endfunction

    // SPI master model
    int          spi_len = 40;
    logic        hang = 1'b0;
    logic        rsp_ovr_en = 1'b0;
    logic [15:0] rsp_ovr = 16'h0;
    logic [15:0] m_cmd;
    int          m_i;

    initial begin
        spi_SS_n = 1'b1;
        spi_done = 1'b0;
        spi_rsp  = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && spi_wrt) begin
                m_cmd    = spi_cmd;
                spi_SS_n = 1'b0;
                m_i      = 0;
                if (hang) begin
                    while (rst_n && !(inert_done || a2d_done) && m_i < TIMEOUT + 100) begin
                        @(posedge clk); #1; m_i++;
                    end
                    spi_SS_n = 1'b1;
                    if (rst_n) begin
                        @(posedge clk); #1;
                        spi_rsp  = 16'hBEEF;
                        spi_done = 1'b1;
                        @(posedge clk); #1;
                        spi_done = 1'b0;
                    end
                end else begin
                    while (rst_n && m_i < spi_len) begin
                        @(posedge clk); #1; m_i++;
                    end
                    if (rst_n) begin
                        spi_rsp  = rsp_ovr_en ? rsp_ovr : ~m_cmd;
                        spi_done = 1'b1;
                        @(posedge clk); #1;
                        spi_done = 1'b0;
                    end
                    spi_SS_n = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard
    int   cyc = 0;
    int   wrt_cnt = 0;
    int   done_cnt = 0;
    int   last_wrt_cyc = 0;
    int   last_done_cyc = 0;
    logic have_done = 1'b0;
    logic active = 1'b0;
    logic act_own = 1'b0;
    exp_t m_e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (spi_wrt) begin
                    wrt_cnt++;
                    if (q_wrt.size() == 0) begin
                        fail("spi_wrt", $sformatf("unexpected pulse, cmd %0h", spi_cmd));
                    end else begin
                        m_e = q_wrt.pop_front();
                        chk("spi_cmd", spi_cmd, m_e.val);
                        chk("owner", owner, m_e.own);
                        act_own = m_e.own;
                    end
                    if (have_done)
                        chk("turnaround", (cyc - last_done_cyc) >= GAP_CYC + 3, 1);
                    last_wrt_cyc = cyc;
                    active = 1'b1;
                end
                chk("INERT_SS_n", INERT_SS_n, (active && act_own == 1'b0) ? spi_SS_n : 1'b1);
                chk("A2D_SS_n", A2D_SS_n, (active && act_own == 1'b1) ? spi_SS_n : 1'b1);
                if (inert_done || a2d_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    have_done = 1'b1;
                    if (inert_done && a2d_done)
                        fail("done", "both done pulses at once");
                    if (q_done.size() == 0) begin
                        fail("done", $sformatf("unexpected done, inert %0b a2d %0b", inert_done, a2d_done));
                    end else begin
                        m_e = q_done.pop_front();
                        chk("done_owner", a2d_done, m_e.own);
                        chk("rsp", m_e.own ? a2d_rsp : inert_rsp, m_e.val);
                        if (m_e.lat > 0)
                            chk("wrt_to_done", cyc - last_wrt_cyc, m_e.lat);
                    end
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_done(int target, int budget, string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        if (done_cnt < target) fail(name, "timed out waiting for done");
    endtask

    task automatic wait_wrt(int target, int budget, string name);
        int k;
        k = 0;
        while (wrt_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        if (wrt_cnt < target) fail(name, "timed out waiting for spi_wrt");
    endtask

    int d0;

    initial begin
        rst_n = 1'b0; inert_req = 1'b0; a2d_req = 1'b0; err_clr = 1'b0;
        inert_cmd = 16'h0; a2d_cmd = 16'h0;
        tick(3);
        chk("rst_inert_done", inert_done, 0);
        chk("rst_a2d_done", a2d_done, 0);
        chk("rst_spi_wrt", spi_wrt, 0);
        chk("rst_spi_cmd", spi_cmd, 0);
        chk("rst_owner", owner, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_INERT_SS_n", INERT_SS_n, 1);
        chk("rst_A2D_SS_n", A2D_SS_n, 1);
        chk("rst_inert_rsp", inert_rsp, 0);
        chk("rst_a2d_rsp", a2d_rsp, 0);
        rst_n = 1'b1;
        tick(2);

        // Lone inertial request
        spi_len = 40; rsp_ovr_en = 1'b1; rsp_ovr = 16'h1234;
        push_w(1'b0, 16'hA5A5); push_d(1'b0, 16'h1234, 41);
        inert_cmd = 16'hA5A5; inert_req = 1'b1;
        wait_done(1, 200, "t1_done");
        inert_req = 1'b0;
        tick(12);

        // Lone A2D request; inertial response must stay put
        rsp_ovr = 16'h0ABC;
        push_w(1'b1, 16'h6800); push_d(1'b1, 16'h0ABC, 41);
        a2d_cmd = 16'h6800; a2d_req = 1'b1;
        wait_done(2, 200, "t3_done");
        a2d_req = 1'b0;
        chk("t3_inert_rsp_kept", inert_rsp, 16'h1234);
        tick(12);

        // Both held: I,I,I,I,A twice
        rsp_ovr_en = 1'b0; spi_len = 20;
        inert_cmd = 16'hC001; a2d_cmd = 16'h6808;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                push_w(1'b1, 16'h6808); push_d(1'b1, 16'h97F7, 21);
            end else begin
                push_w(1'b0, 16'hC001); push_d(1'b0, 16'h3FFE, 21);
            end
        end
        inert_req = 1'b1; a2d_req = 1'b1;
        wait_done(12, 800, "t2_done");
        inert_req = 1'b0; a2d_req = 1'b0;
        tick(12);

        // Request raised during GAP
        push_w(1'b0, 16'hC001); push_d(1'b0, 16'h3FFE, 21);
        inert_req = 1'b1;
        wait_done(13, 100, "t6_first_done");
        inert_req = 1'b0;
        d0 = last_done_cyc;
        tick(3);
        push_w(1'b1, 16'h6810); push_d(1'b1, 16'h97EF, 21);
        a2d_cmd = 16'h6810; a2d_req = 1'b1;
        wait_wrt(14, 40, "t6_wrt");
        chk("t6_wrt_delay", last_wrt_cyc - d0, GAP_CYC + 3);
        wait_done(14, 100, "t6_done");
        a2d_req = 1'b0;
        tick(12);

        // Watchdog: err_clr held through the timeout cycle, set must win
        hang = 1'b1;
        push_w(1'b0, 16'h1111); push_d(1'b0, 16'hFFFF, TIMEOUT);
        inert_cmd = 16'h1111; inert_req = 1'b1; err_clr = 1'b1;
        wait_done(15, TIMEOUT + 100, "t4_timeout_done");
        inert_req = 1'b0; err_clr = 1'b0;
        chk("t4_err_set", timeout_err, 1);
        tick(6);
        hang = 1'b0;
        chk("t4_rsp_after_late_done", inert_rsp, 16'hFFFF);
        chk("t4_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_err_clr", timeout_err, 0);
        tick(6);
        push_w(1'b0, 16'hA5A5); push_d(1'b0, 16'h5A5A, 21);
        inert_cmd = 16'hA5A5; inert_req = 1'b1;
        wait_done(16, 100, "t4_next_done");
        inert_req = 1'b0;
        chk("t4_err_stays_clear", timeout_err, 0);
        tick(12);

        // Reset in BUSY of the third inertial grant; consec must restart at 0
        spi_len = 30;
        inert_cmd = 16'hC001; a2d_cmd = 16'h6808;
        for (int i = 0; i < 3; i++) push_w(1'b0, 16'hC001);
        for (int i = 0; i < 2; i++) push_d(1'b0, 16'h3FFE, 31);
        inert_req = 1'b1; a2d_req = 1'b1;
        wait_wrt(19, 200, "t5_wrt_pre");
        tick(10);
        chk("t5_inert_ss_busy", INERT_SS_n, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_INERT_SS_n", INERT_SS_n, 1);
        chk("t5_rst_A2D_SS_n", A2D_SS_n, 1);
        chk("t5_rst_spi_wrt", spi_wrt, 0);
        chk("t5_rst_inert_done", inert_done, 0);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                push_w(1'b1, 16'h6808); push_d(1'b1, 16'h97F7, 31);
            end else begin
                push_w(1'b0, 16'hC001); push_d(1'b0, 16'h3FFE, 31);
            end
        end
        rst_n = 1'b1;
        wait_done(23, 600, "t5_done");
        inert_req = 1'b0; a2d_req = 1'b0;
        tick(15);

        chk("end_wrt_queue_empty", q_wrt.size(), 0);
        chk("end_done_queue_empty", q_done.size(), 0);
        chk("end_done_count", done_cnt, 23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
